beat_spawn_scheduler: RTL and testbench

Sequences the six falling-block lanes of the piano game from the shared beat counter. Holds the song chart (beat number → lane mask), detects each new beat, and issues one-cycle spawn pulses to the per-lane block generators. Also owns the game-phase FSM (idle / play / pause / done) that gates spawning. Sits between the beat counter and the lane block modules, on the same clock as those modules.

---
 rtl/beat_spawn_scheduler.sv | 144 ++++++++++++++
 tb/tb_beat_spawn_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_spawn_scheduler.sv
// beat_spawn_scheduler
//
// Sequences the six falling-block lanes from the shared beat counter. Holds the
// song chart (beat -> lane mask), detects each newly arrived beat, and issues
// one-cycle spawn pulses to the lane block generators. Also owns the game-phase
// FSM (idle / play / pause / done) that gates spawning.
//
// Optional feature macro: SPAWN_CATCHUP_EN
//   defined   : when the beat counter jumps ahead, skipped beats are replayed
//               one per cycle so none of their notes are lost.
//   undefined : only the newest beat is spawned; skipped beats are dropped.
//
// Ports:
//   clk             clock shared with the beat counter and lane blocks
//   rst_n           synchronous active-low reset
//   restart         synchronous game restart (same clear as rst_n)
//   start           one-cycle request to leave IDLE
//   stop_or_endgame level pause request
//   beat_cnt[6:0]   current beat number
//   spawn[5:0]      one-cycle lane spawn pulses, bit k drives lane k
//   state[1:0]      IDLE=0, PLAY=1, PAUSE=2, DONE=3
//   note_cnt[7:0]   total notes spawned, saturating at 255
//   game_done       high while in DONE
module beat_spawn_scheduler #(
    parameter int unsigned END_BEAT = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       start,
    input  logic       stop_or_endgame,
    input  logic [6:0] beat_cnt,
    output logic [5:0] spawn,
    output logic [1:0] state,
    output logic [7:0] note_cnt,
    output logic       game_done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [6:0] EndBeat = 7'(END_BEAT);

    state_e     state_q;
    logic [6:0] pre_beat_q;
    logic [5:0] spawn_q;
    logic [7:0] note_cnt_q;
    logic       game_done_q;

    logic [6:0] adv_beat;
    logic [5:0] adv_mask;
    logic [2:0] adv_pop;
    logic [8:0] cnt_sum;
    logic [7:0] cnt_next;

    // Beat processed on an advance: the next beat in sequence when catching
    // up, otherwise whatever the counter shows now.
`ifdef SPAWN_CATCHUP_EN
    assign adv_beat = pre_beat_q + 7'd1;
`else
    assign adv_beat = beat_cnt;
`endif

    // Song chart ROM
    always_comb begin
        adv_mask    = '0;
        adv_mask[0] = adv_beat inside {7'd1, 7'd13, 7'd25, 7'd37, 7'd61, 7'd81};
        adv_mask[1] = adv_beat inside {7'd5, 7'd17, 7'd29, 7'd41, 7'd63, 7'd83};
        adv_mask[2] = adv_beat inside {7'd7, 7'd19, 7'd31, 7'd47, 7'd65, 7'd85};
        adv_mask[3] = adv_beat inside {7'd9, 7'd23, 7'd35, 7'd49, 7'd67, 7'd89};
        adv_mask[4] = adv_beat inside {7'd11, 7'd27, 7'd39, 7'd53, 7'd71, 7'd91};
        adv_mask[5] = adv_beat inside {7'd3, 7'd21, 7'd33, 7'd45, 7'd51, 7'd57,
                                       7'd69, 7'd75, 7'd87};
    end

    // Saturating note counter increment
    always_comb begin
        adv_pop = '0;
        for (int k = 0; k < 6; k++) begin
            adv_pop = adv_pop + {2'b00, adv_mask[k]};
        end
        cnt_sum  = {1'b0, note_cnt_q} + {6'd0, adv_pop};
        cnt_next = cnt_sum[8] ? 8'hff : cnt_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            state_q     <= StIdle;
            pre_beat_q  <= '0;
            spawn_q     <= '0;
            note_cnt_q  <= '0;
            game_done_q <= 1'b0;
        end else begin
            // Spawn is a single-cycle pulse; only an advance raises it.
            spawn_q <= '0;
            unique case (state_q)
                StIdle: begin
                    pre_beat_q <= beat_cnt;
                    if (start) begin
                        state_q <= StPlay;
                    end
                end
                StPlay: begin
                    if (stop_or_endgame) begin
                        // Pause wins over a simultaneous beat change.
                        state_q <= StPause;
                    end else if (beat_cnt > pre_beat_q) begin
                        pre_beat_q <= adv_beat;
                        spawn_q    <= adv_mask;
                        note_cnt_q <= cnt_next;
                    end else if (beat_cnt < pre_beat_q) begin
                        // Counter wrapped or was reloaded: resync silently.
                        pre_beat_q <= beat_cnt;
                    end else if (pre_beat_q >= EndBeat) begin
                        // Reached only a cycle after the final advance, so the
                        // last spawn pulse has already gone out.
                        state_q     <= StDone;
                        game_done_q <= 1'b1;
                    end
                end
                StPause: begin
                    // Beats passing during a pause are discarded.
                    pre_beat_q <= beat_cnt;
                    if (!stop_or_endgame) begin
                        state_q <= StPlay;
                    end
                end
                StDone: begin
                    game_done_q <= 1'b1;
                end
            endcase
        end
    end

    assign spawn     = spawn_q;
    assign state     = state_q;
    assign note_cnt  = note_cnt_q;
    assign game_done = game_done_q;

endmodule

// File: tb/tb_beat_spawn_scheduler.sv
// tb_beat_spawn_scheduler
//
// Self-checking bench for beat_spawn_scheduler. A behavioural reference model
// (chart held as per-lane beat lists, state as plain integers) is stepped at
// every rising edge with the same inputs the DUT sees; outputs are compared
// 1 time unit after the edge. Honours SPAWN_CATCHUP_EN like the design.
module tb_beat_spawn_scheduler;

    localparam int END_BEAT = 96;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       restart = 1'b0;
    logic       start = 1'b0;
    logic       stop_or_endgame = 1'b0;
    logic [6:0] beat_cnt = '0;
    logic [5:0] spawn;
    logic [1:0] state;
    logic [7:0] note_cnt;
    logic       game_done;

    int n_checks = 0;
    int n_fail = 0;

    beat_spawn_scheduler #(
        .END_BEAT(END_BEAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .restart        (restart),
        .start          (start),
        .stop_or_endgame(stop_or_endgame),
        .beat_cnt       (beat_cnt),
        .spawn          (spawn),
        .state          (state),
        .note_cnt       (note_cnt),
        .game_done      (game_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int lane_beats [6][9] = '{
        '{1, 13, 25, 37, 61, 81, 0, 0, 0},
        '{5, 17, 29, 41, 63, 83, 0, 0, 0},
        '{7, 19, 31, 47, 65, 85, 0, 0, 0},
        '{9, 23, 35, 49, 67, 89, 0, 0, 0},
        '{11, 27, 39, 53, 71, 91, 0, 0, 0},
        '{3, 21, 33, 45, 51, 57, 69, 75, 87}
    };

    int m_state = 0;   // 0 idle, 1 play, 2 pause, 3 done
    int m_pre = 0;
    int m_spawn = 0;
    int m_cnt = 0;
    int m_done = 0;

    function automatic int chart_mask(int b);
        int m = 0;
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 9; j++) begin
                if (b != 0 && lane_beats[k][j] == b) m = m | (1 << k);
            end
        end
        return m;
    endfunction

    function automatic int count_bits(int v);
        int c = 0;
        for (int k = 0; k < 6; k++) c += (v >> k) & 1;
        return c;
    endfunction

    task automatic model_step();
        int b = int'(beat_cnt);
        int nb;
        if (!rst_n || restart) begin
            m_state = 0; m_pre = 0; m_spawn = 0; m_cnt = 0; m_done = 0;
            return;
        end
        m_spawn = 0;
        case (m_state)
            0: begin
                m_pre = b;
                if (start) m_state = 1;
            end
            1: begin
                if (stop_or_endgame) m_state = 2;
                else if (b > m_pre) begin
`ifdef SPAWN_CATCHUP_EN
                    nb = m_pre + 1;
`else
                    nb = b;
`endif
                    m_pre = nb;
                    m_spawn = chart_mask(nb);
                    m_cnt = m_cnt + count_bits(m_spawn);
                    if (m_cnt > 255) m_cnt = 255;
                end else if (b < m_pre) m_pre = b;
                else if (m_pre >= END_BEAT) m_state = 3;
            end
            2: begin
                m_pre = b;
                if (!stop_or_endgame) m_state = 1;
            end
            default: ;
        endcase
        m_done = (m_state == 3) ? 1 : 0;
    endtask

    function automatic logic [16:0] mdl_vec();
        return {6'(m_spawn), 2'(m_state), 8'(m_cnt), 1'(m_done)};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {spawn, state, note_cnt, game_done};
    endfunction

    // Advance one clock; model sees the same inputs as the DUT at the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input logic [6:0] b);
        rst_n = 1'b0; restart = 1'b0; start = 1'b0; stop_or_endgame = 1'b0;
        beat_cnt = b;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        beat_cnt = 7'd42;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (dut_vec() !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), 17'd0);
        end
        rst_n = 1'b1;
        beat_cnt = 7'd43;
        tick();
        n_checks++;
        if (state !== 2'd0 || spawn !== 6'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got state %0d spawn %b want 0 0", state, spawn);
        end
    endtask

    task automatic test_basic_steps();
        int seen_l0 = 0;
        int seen_l5 = 0;
        do_reset(7'd0);
        do_start();
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL start_to_play: got %0d want 1", state);
        end
        for (int b = 1; b <= 3; b++) begin
            beat_cnt = 7'(b);
            for (int c = 0; c < 10; c++) begin
                tick();
                if (spawn === 6'b000001) seen_l0++;
                if (spawn === 6'b100000) seen_l5++;
                n_checks++;
                if (dut_vec() !== mdl_vec()) begin
                    n_fail++;
                    $display("FAIL basic_cycle: beat %0d got %h want %h", b, dut_vec(), mdl_vec());
                end
            end
        end
        n_checks++;
        if (seen_l0 != 1 || seen_l5 != 1 || note_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL basic_summary: got l0=%0d l5=%0d cnt=%0d want 1 1 2",
                     seen_l0, seen_l5, note_cnt);
        end
    endtask

    task automatic test_pause();
        int bad_spawn = 0;
        do_reset(7'd20);
        do_start();
        stop_or_endgame = 1'b1;
        tick();
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL pause_enter: got %0d want 2", state);
        end
        beat_cnt = 7'd21;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (spawn !== 6'd0) bad_spawn++;
        end
        stop_or_endgame = 1'b0;
        tick();
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL pause_resume: got %0d want 1", state);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (spawn !== 6'd0) bad_spawn++;
        end
        n_checks++;
        if (bad_spawn != 0 || note_cnt !== 8'd0 || dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL pause_discard: got spawns=%0d cnt=%0d want 0 0", bad_spawn, note_cnt);
        end
    endtask

    task automatic test_jump();
        int pulses = 0;
`ifdef SPAWN_CATCHUP_EN
        int exp_cnt = 3;
        int exp_pulses = 3;
`else
        int exp_cnt = 1;
        int exp_pulses = 1;
`endif
        do_reset(7'd0);
        do_start();
        beat_cnt = 7'd5;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (spawn !== 6'd0) pulses++;
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL jump_cycle: cyc %0d got %h want %h", c, dut_vec(), mdl_vec());
            end
        end
        n_checks++;
        if (note_cnt !== 8'(exp_cnt) || pulses != exp_pulses) begin
            n_fail++;
            $display("FAIL jump_summary: got cnt=%0d pulses=%0d want %0d %0d",
                     note_cnt, pulses, exp_cnt, exp_pulses);
        end
    endtask

    task automatic test_sweep_and_restart();
        int errs = 0;
        do_reset(7'd0);
        do_start();
        for (int b = 1; b <= 100; b++) begin
            beat_cnt = 7'(b);
            for (int c = 0; c < 4; c++) begin
                tick();
                if (dut_vec() !== mdl_vec()) errs++;
                if (b > END_BEAT && spawn !== 6'd0) errs++;
            end
            if (b == END_BEAT) begin
                n_checks++;
                if (state !== 2'd3 || game_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sweep_done: got state %0d done %b want 3 1", state, game_done);
                end
            end
        end
        n_checks++;
        if (errs != 0 || note_cnt !== 8'd39) begin
            n_fail++;
            $display("FAIL sweep: got errs=%0d cnt=%0d want 0 39", errs, note_cnt);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_checks++;
        if (dut_vec() !== 17'd0) begin
            n_fail++;
            $display("FAIL restart_done: got %h want 0", dut_vec());
        end
        // Restart and reset each coinciding with a spawn edge
        for (int v = 0; v < 2; v++) begin
            do_reset(7'd0);
            do_start();
            beat_cnt = 7'd1;
            tick();
            n_checks++;
            if (spawn !== 6'b000001) begin
                n_fail++;
                $display("FAIL mid_spawn_setup: got %b want 000001", spawn);
            end
            if (v == 0) restart = 1'b1;
            else rst_n = 1'b0;
            tick();
            restart = 1'b0;
            rst_n = 1'b1;
            n_checks++;
            if (dut_vec() !== 17'd0) begin
                n_fail++;
                $display("FAIL mid_spawn_clear%0d: got %h want 0", v, dut_vec());
            end
        end
    endtask

    task automatic test_wrap();
        int bad = 0;
        do_reset(7'd50);
        do_start();
        beat_cnt = 7'd10;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (spawn !== 6'd0) bad++;
        end
        n_checks++;
        if (bad != 0 || dut_vec() !== mdl_vec() || m_pre != 10) begin
            n_fail++;
            $display("FAIL wrap_silent: got spawns=%0d vec %h want 0 %h", bad, dut_vec(), mdl_vec());
        end
        beat_cnt = 7'd11;
        tick();
        n_checks++;
        if (spawn !== 6'b010000) begin
            n_fail++;
            $display("FAIL wrap_next: got %b want 010000", spawn);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        int r;
        do_reset(7'(0));
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 199);
            rst_n = (r != 0);
            restart = (r == 1);
            start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 24) == 0) stop_or_endgame = ~stop_or_endgame;
            r = $urandom_range(0, 99);
            if (r < 15) beat_cnt = (beat_cnt == 7'd127) ? beat_cnt : beat_cnt + 7'd1;
            else if (r < 18) beat_cnt = beat_cnt + 7'($urandom_range(2, 6));
            else if (r < 19) beat_cnt = 7'($urandom_range(0, 127));
            tick();
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle: cyc %0d got %h want %h", c, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_steps();
        test_pause();
        test_jump();
        test_sweep_and_restart();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
